mandelbrot_tile_engine: RTL and testbench

MANDELBROT_TILE_ENGINE -- requirements
Module: mandelbrot_tile_engine

---
 rtl/mandelbrot_pkg.sv | 69 ++++++
 rtl/mandelbrot_pe.sv | 107 ++++++++++
 rtl/mandelbrot_tile_engine.sv | 180 ++++++++++++++++++
 tb/tb_mandelbrot_tile_engine.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mandelbrot_pkg.sv
// Shared types, FSM encoding, config word field offsets and fixed-point helpers
// for the Mandelbrot tile engine.
package mandelbrot_pkg;

  localparam int FRAC_BITS_DEF     = 29;
  localparam int EXT_FRAC_BITS_DEF = 39;
  localparam int FIXED_W           = FRAC_BITS_DEF + 4;
  localparam int EXT_FIXED_W       = EXT_FRAC_BITS_DEF + 4;
  localparam int WORK_W            = 64;

  typedef logic signed [FIXED_W-1:0]     fixed_t;
  typedef logic signed [EXT_FIXED_W-1:0] ext_fixed_t;
  typedef logic signed [WORK_W-1:0]      work_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    ITER = 2'd2,
    EMIT = 2'd3
  } state_e;

  localparam int CFG_MIN_X_OFS     = 0;
  localparam int CFG_MIN_Y_OFS     = 64;
  localparam int CFG_PIX_X_OFS     = 128;
  localparam int CFG_PIX_Y_OFS     = 192;
  localparam int CFG_SIZE_X_OFS    = 256;
  localparam int CFG_SIZE_Y_OFS    = 320;
  localparam int CFG_MAX_DEPTH_OFS = 384;

  // IEEE double to two's complement fixed point, truncating the magnitude toward zero.
  function automatic work_t real_to_fixed(input logic [63:0] d, input int frac);
    logic [10:0] e;
    logic [52:0] man;
    logic [63:0] mag;
    int          sh;
    e   = d[62:52];
    man = {1'b1, d[51:0]};
    sh  = int'({21'b0, e}) - 1075 + frac;
    mag = '0;
    if (e == 11'd0) begin
      mag = '0;
    end else if (sh >= 0) begin
      if (sh > 10) mag = 64'h7FFF_FFFF_FFFF_FFFF;
      else         mag = {11'b0, man} << sh;
    end else if (sh > -53) begin
      mag = {11'b0, man} >> (-sh);
    end
    return d[63] ? -$signed(mag) : $signed(mag);
  endfunction

  function automatic work_t real_to_ext_fixed(input logic [63:0] d, input int ext_frac);
    return real_to_fixed(d, ext_frac);
  endfunction

  function automatic work_t fixed_mul(input work_t a, input work_t b, input int frac);
    logic signed [127:0] a_x;
    logic signed [127:0] b_x;
    logic signed [127:0] p;
    a_x = {{64{a[63]}}, a};
    b_x = {{64{b[63]}}, b};
    p   = (a_x * b_x) >>> frac;
    return p[63:0];
  endfunction

  function automatic work_t fixed_add(input work_t a, input work_t b);
    return a + b;
  endfunction

endpackage

// File: rtl/mandelbrot_pe.sv
// One escape-time lane: loads its coordinate in INIT, then iterates z = z^2 + c
// until it escapes or hits max_depth, and holds the frozen depth.
module mandelbrot_pe
  import mandelbrot_pkg::*;
#(
  parameter int FRAC_BITS  = 29,
  parameter int DEPTH_BITS = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      init_i,
  input  logic                      iter_i,
  input  logic                      active_i,
  input  logic signed [FRAC_BITS+3:0] x_init_i,
  input  logic signed [FRAC_BITS+3:0] y_init_i,
  input  logic [31:0]               max_depth_i,
  output logic                      frozen_next_o,
  output logic [DEPTH_BITS-1:0]     depth_o
);

  localparam int          FW    = FRAC_BITS + 4;
  localparam work_t       TWO   = 64'sd2 <<< FRAC_BITS;
  localparam work_t       FOUR  = 64'sd4 <<< FRAC_BITS;
  localparam work_t       FMAX  = (64'sd1 <<< (FW - 1)) - 64'sd1;
  localparam work_t       FMIN  = -(64'sd1 <<< (FW - 1));
  localparam logic [31:0] DMAX  = 32'((64'd1 << DEPTH_BITS) - 64'd1);

  logic signed [FW-1:0]   a_q, a_d, b_q, b_d, x_q, x_d, y_q, y_d;
  logic [31:0]            k_q, k_d;
  logic                   frozen_q, frozen_d;
  logic [DEPTH_BITS-1:0]  depth_q, depth_d;

  work_t a_w, b_w, x_w, y_w, aa, bb, ab;
  logic  escape;

  // Clamp instead of wrapping so an out-of-range result still trips the |a|,|b| >= 2 test.
  function automatic logic signed [FW-1:0] sat_fw(input work_t v);
    if (v > FMAX)      return FMAX[FW-1:0];
    else if (v < FMIN) return FMIN[FW-1:0];
    else               return v[FW-1:0];
  endfunction

  assign a_w = work_t'(a_q);
  assign b_w = work_t'(b_q);
  assign x_w = work_t'(x_q);
  assign y_w = work_t'(y_q);
  assign aa  = fixed_mul(a_w, a_w, FRAC_BITS);
  assign bb  = fixed_mul(b_w, b_w, FRAC_BITS);
  assign ab  = fixed_mul(a_w, b_w, FRAC_BITS);

  assign escape = (fixed_add(aa, bb) >= FOUR) ||
                  (a_w >= TWO) || (a_w <= -TWO) ||
                  (b_w >= TWO) || (b_w <= -TWO) ||
                  (k_q == max_depth_i);

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    x_d      = x_q;
    y_d      = y_q;
    k_d      = k_q;
    frozen_d = frozen_q;
    depth_d  = depth_q;
    if (init_i) begin
      a_d      = '0;
      b_d      = '0;
      k_d      = '0;
      x_d      = x_init_i;
      y_d      = y_init_i;
      frozen_d = !active_i;
      depth_d  = '0;
    end else if (iter_i && !frozen_q) begin
      if (escape) begin
        frozen_d = 1'b1;
        depth_d  = (k_q > DMAX) ? '1 : k_q[DEPTH_BITS-1:0];
      end else begin
        a_d = sat_fw(fixed_add(fixed_add(aa, -bb), x_w));
        b_d = sat_fw(fixed_add(ab <<< 1, y_w));
        k_d = k_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      k_q      <= '0;
      frozen_q <= 1'b0;
      depth_q  <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      x_q      <= x_d;
      y_q      <= y_d;
      k_q      <= k_d;
      frozen_q <= frozen_d;
      depth_q  <= depth_d;
    end
  end

  assign frozen_next_o = frozen_d;
  assign depth_o       = depth_q;

endmodule

// File: rtl/mandelbrot_tile_engine.sv
// Mandelbrot tile engine: takes one config word, sweeps the frame NUM_PE pixels at a
// time and emits one depth beat per group. Define MANDEL_POS_TAG_EN to tag beats with {row, base_h}.
module mandelbrot_tile_engine
  import mandelbrot_pkg::*;
#(
  parameter int C_DATA_WIDTH  = 512,
  parameter int NUM_PE        = 8,
  parameter int FRAC_BITS     = 29,
  parameter int EXT_FRAC_BITS = 39,
  parameter int DEPTH_BITS    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_avail,
  output logic                    in_blocked,
  input  logic [C_DATA_WIDTH-1:0] in_data,
  output logic                    out_avail,
  input  logic                    out_blocked,
  output logic [C_DATA_WIDTH-1:0] out_data,
  output logic                    frame_done
);

  localparam int FW = FRAC_BITS + 4;
  localparam int EW = EXT_FRAC_BITS + 4;
  localparam int SH = EXT_FRAC_BITS - FRAC_BITS;
  localparam int PW = 128;

  state_e                state_q, state_d;
  logic signed [FW-1:0]  min_x_q, min_y_q;
  logic signed [EW-1:0]  pix_x_q, pix_y_q;
  logic [31:0]           size_x_q, size_y_q, max_depth_q;
  logic [31:0]           base_h_q, base_h_d, row_q, row_d;
  logic                  frame_done_q, frame_done_d;
  logic                  cfg_load;

  work_t                 cvt_min_x, cvt_min_y, cvt_pix_x, cvt_pix_y;
  logic [31:0]           cfg_size_x, cfg_size_y;
  logic                  row_end, last_row;

  logic signed [PW-1:0]  min_x_w, min_y_w, pix_x_w, pix_y_w, y_ext;
  logic signed [FW-1:0]  y_init;
  logic [NUM_PE-1:0]     pe_frozen_next;
  logic [DEPTH_BITS-1:0] pe_depth [NUM_PE];

  assign cvt_min_x  = real_to_fixed(in_data[CFG_MIN_X_OFS +: 64], FRAC_BITS);
  assign cvt_min_y  = real_to_fixed(in_data[CFG_MIN_Y_OFS +: 64], FRAC_BITS);
  assign cvt_pix_x  = real_to_ext_fixed(in_data[CFG_PIX_X_OFS +: 64], EXT_FRAC_BITS);
  assign cvt_pix_y  = real_to_ext_fixed(in_data[CFG_PIX_Y_OFS +: 64], EXT_FRAC_BITS);
  assign cfg_size_x = in_data[CFG_SIZE_X_OFS +: 32];
  assign cfg_size_y = in_data[CFG_SIZE_Y_OFS +: 32];

  assign row_end  = ({1'b0, base_h_q} + 33'(NUM_PE)) >= {1'b0, size_x_q};
  assign last_row = ({1'b0, row_q} + 33'd1) >= {1'b0, size_y_q};

  always_comb begin
    state_d      = state_q;
    base_h_d     = base_h_q;
    row_d        = row_q;
    frame_done_d = 1'b0;
    cfg_load     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_avail) begin
          cfg_load = 1'b1;
          base_h_d = '0;
          row_d    = '0;
          if (cfg_size_x == 32'd0 || cfg_size_y == 32'd0) frame_done_d = 1'b1;
          else                                            state_d      = INIT;
        end
      end
      INIT: state_d = ITER;
      // Exit as soon as every lane is frozen after this cycle's update.
      ITER: if (&pe_frozen_next) state_d = EMIT;
      EMIT: begin
        if (!out_blocked) begin
          if (!row_end) begin
            base_h_d = base_h_q + 32'(NUM_PE);
            state_d  = INIT;
          end else if (!last_row) begin
            base_h_d = '0;
            row_d    = row_q + 32'd1;
            state_d  = INIT;
          end else begin
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      base_h_q     <= '0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
      min_x_q      <= '0;
      min_y_q      <= '0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      size_x_q     <= '0;
      size_y_q     <= '0;
      max_depth_q  <= '0;
    end else begin
      state_q      <= state_d;
      base_h_q     <= base_h_d;
      row_q        <= row_d;
      frame_done_q <= frame_done_d;
      if (cfg_load) begin
        min_x_q     <= cvt_min_x[FW-1:0];
        min_y_q     <= cvt_min_y[FW-1:0];
        pix_x_q     <= cvt_pix_x[EW-1:0];
        pix_y_q     <= cvt_pix_y[EW-1:0];
        size_x_q    <= cfg_size_x;
        size_y_q    <= cfg_size_y;
        max_depth_q <= in_data[CFG_MAX_DEPTH_OFS +: 32];
      end
    end
  end

  // Coordinates are formed at extended precision, then the low SH fraction bits are dropped.
  assign min_x_w = PW'(min_x_q) <<< SH;
  assign min_y_w = PW'(min_y_q) <<< SH;
  assign pix_x_w = PW'(pix_x_q);
  assign pix_y_w = PW'(pix_y_q);
  assign y_ext   = min_y_w + pix_y_w * PW'($signed({1'b0, row_q}));
  assign y_init  = y_ext[SH +: FW];

  for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_pe
    logic [31:0]          h;
    logic signed [PW-1:0] x_ext;
    logic signed [FW-1:0] x_init;
    logic                 unused_x;

    assign h        = base_h_q + 32'(gi);
    assign x_ext    = min_x_w + pix_x_w * PW'($signed({1'b0, h}));
    assign x_init   = x_ext[SH +: FW];
    assign unused_x = ^x_ext;

    mandelbrot_pe #(
      .FRAC_BITS  (FRAC_BITS),
      .DEPTH_BITS (DEPTH_BITS)
    ) u_pe (
      .clk           (clk),
      .reset         (reset),
      .init_i        (state_q == INIT),
      .iter_i        (state_q == ITER),
      .active_i      (h < size_x_q),
      .x_init_i      (x_init),
      .y_init_i      (y_init),
      .max_depth_i   (max_depth_q),
      .frozen_next_o (pe_frozen_next[gi]),
      .depth_o       (pe_depth[gi])
    );
  end

  assign in_blocked = !reset && (state_q != IDLE);
  assign out_avail  = !reset && (state_q == EMIT);
  assign frame_done = !reset && frame_done_q;

  always_comb begin
    out_data = '0;
    if (!reset && state_q == EMIT) begin
      for (int i = 0; i < NUM_PE; i++) begin
        out_data[DEPTH_BITS*i +: DEPTH_BITS] = pe_depth[i];
      end
`ifdef MANDEL_POS_TAG_EN
      out_data[C_DATA_WIDTH-1 -: 64] = {row_q, base_h_q};
`else
      out_data[C_DATA_WIDTH-1 -: 64] = 64'd0;
`endif
    end
  end

  logic unused_ok;
  assign unused_ok = ^{in_data, cvt_min_x, cvt_min_y, cvt_pix_x, cvt_pix_y, y_ext};

endmodule

// File: tb/tb_mandelbrot_tile_engine.sv
// Directed bench for mandelbrot_tile_engine (default parameters, NUM_PE=8):
// hand-computed depth beats, frame_done timing, stall, reset mid-frame.
module tb_mandelbrot_tile_engine;

  localparam int DW = 512;
`ifdef MANDEL_POS_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_avail = 1'b0;
  logic          out_blocked = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_blocked;
  logic          out_avail;
  logic [DW-1:0] out_data;
  logic          frame_done;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  mandelbrot_tile_engine dut (
    .clk         (clk),
    .reset       (reset),
    .in_avail    (in_avail),
    .in_blocked  (in_blocked),
    .in_data     (in_data),
    .out_avail   (out_avail),
    .out_blocked (out_blocked),
    .out_data    (out_data),
    .frame_done  (frame_done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] make_cfg(input real mx, input real my, input real px,
                                             input real py, input logic [31:0] sx,
                                             input logic [31:0] sy, input logic [31:0] md);
    logic [DW-1:0] w;
    w = '0;
    w[0   +: 64] = $realtobits(mx);
    w[64  +: 64] = $realtobits(my);
    w[128 +: 64] = $realtobits(px);
    w[192 +: 64] = $realtobits(py);
    w[256 +: 32] = sx;
    w[320 +: 32] = sy;
    w[384 +: 32] = md;
    return w;
  endfunction

  // Called at a negedge; leaves the word presented across exactly one posedge.
  task automatic send_cfg(input logic [DW-1:0] w);
    int guard;
    guard = 0;
    while (in_blocked !== 1'b0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("send_ready", {63'b0, in_blocked}, 64'd0);
    in_avail = 1'b1;
    in_data  = w;
    @(negedge clk);
    in_avail = 1'b0;
  endtask

  task automatic get_beat(input string tag, input int exp_lat, input bit last,
                          input logic [63:0] exp_tag);
    int          cyc;
    logic [63:0] exp;
    logic [63:0] want_tag;
    cyc = 0;
    while (out_avail !== 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    if (exp_lat >= 0) check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_avail"}, {63'b0, out_avail}, 64'd1);
    if (out_avail !== 1'b1) return;
    exp      = (exp_q.size() > 0) ? exp_q.pop_front() : 64'd0;
    want_tag = TAG_EN ? exp_tag : 64'd0;
    check({tag, "_depths"}, out_data[63:0], exp);
    check({tag, "_mid0"}, {63'b0, |out_data[DW-65:64]}, 64'd0);
    check({tag, "_tag"}, out_data[DW-1 -: 64], want_tag);
    @(negedge clk);
    check({tag, "_fdone"}, {63'b0, frame_done}, {63'b0, last});
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_avail", {63'b0, out_avail}, 64'd0);
    check("rst_frame_done", {63'b0, frame_done}, 64'd0);
    check("rst_in_blocked", {63'b0, in_blocked}, 64'd0);
    check("rst_out_data", {63'b0, |out_data}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // c=0, depth 5: 1 INIT + 6 ITER cycles before EMIT
    exp_q.push_back(64'h0505_0505_0505_0505);
    send_cfg(make_cfg(0.0, 0.0, 0.0, 0.0, 8, 1, 5));
    get_beat("t1", 7, 1'b1, 64'd0);
    @(negedge clk);
    check("t1_fd_pulse", {63'b0, frame_done}, 64'd0);
    check("t1_idle_avail", {63'b0, out_avail}, 64'd0);

    // c=3.0 escapes after one update
    exp_q.push_back(64'h0101_0101_0101_0101);
    send_cfg(make_cfg(3.0, 0.0, 0.0, 0.0, 8, 1, 100));
    get_beat("t2", 3, 1'b1, 64'd0);

    // x = -2 + 0.5*i on the real axis: depths 1,10,10,10,10,5,2,2
    exp_q.push_back(64'h0202_050A_0A0A_0A01);
    send_cfg(make_cfg(-2.0, 0.0, 0.5, 0.0, 8, 1, 10));
    get_beat("t3", 12, 1'b1, 64'd0);

    // 12x2 frame: partial second group per row
    exp_q.push_back(64'h0303_0303_0303_0303);
    exp_q.push_back(64'h0000_0000_0303_0303);
    exp_q.push_back(64'h0303_0303_0303_0303);
    exp_q.push_back(64'h0000_0000_0303_0303);
    send_cfg(make_cfg(0.0, 0.0, 0.0, 0.0, 12, 2, 3));
    get_beat("t4b1", 5, 1'b0, {32'd0, 32'd0});
    get_beat("t4b2", 5, 1'b0, {32'd0, 32'd8});
    get_beat("t4b3", 5, 1'b0, {32'd1, 32'd0});
    get_beat("t4b4", 5, 1'b1, {32'd1, 32'd8});

    // Downstream stall for 10 cycles; a config offered meanwhile is ignored
    out_blocked = 1'b1;
    exp_q.push_back(64'h0202_0202_0202_0202);
    send_cfg(make_cfg(0.0, 0.0, 0.0, 0.0, 8, 1, 2));
    begin
      int cyc;
      cyc = 0;
      while (out_avail !== 1'b1 && cyc < 1000) begin
        @(negedge clk);
        cyc++;
      end
      check("t5_lat", 64'(cyc), 64'd4);
    end
    for (int i = 0; i < 10; i++) begin
      check("t5_stall_avail", {63'b0, out_avail}, 64'd1);
      check("t5_stall_data", out_data[63:0], 64'h0202_0202_0202_0202);
      check("t5_stall_inblk", {63'b0, in_blocked}, 64'd1);
      check("t5_stall_fd", {63'b0, frame_done}, 64'd0);
      in_avail = 1'b1;
      in_data  = make_cfg(0.0, 0.0, 0.0, 0.0, 0, 1, 1);
      @(negedge clk);
    end
    in_avail    = 1'b0;
    out_blocked = 1'b0;
    get_beat("t5", 0, 1'b1, 64'd0);
    @(negedge clk);
    check("t5_after_fd", {63'b0, frame_done}, 64'd0);
    check("t5_after_avail", {63'b0, out_avail}, 64'd0);

    // Depth saturates at 255
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    send_cfg(make_cfg(0.0, 0.0, 0.0, 0.0, 8, 1, 300));
    get_beat("t6", 302, 1'b1, 64'd0);

    // max_depth = 0: single ITER cycle, all depths 0
    exp_q.push_back(64'd0);
    send_cfg(make_cfg(0.0, 0.0, 0.0, 0.0, 8, 1, 0));
    get_beat("t7", 2, 1'b1, 64'd0);

    // Empty frame: frame_done next cycle, stays idle
    send_cfg(make_cfg(0.0, 0.0, 0.0, 0.0, 0, 4, 5));
    check("t8_fd", {63'b0, frame_done}, 64'd1);
    check("t8_inblk", {63'b0, in_blocked}, 64'd0);
    check("t8_avail", {63'b0, out_avail}, 64'd0);
    @(negedge clk);
    check("t8_fd_clear", {63'b0, frame_done}, 64'd0);

    // Reset during ITER, new config on the first cycle after reset
    send_cfg(make_cfg(0.0, 0.0, 0.0, 0.0, 8, 1, 200));
    repeat (20) @(negedge clk);
    check("t9_iter_inblk", {63'b0, in_blocked}, 64'd1);
    check("t9_iter_avail", {63'b0, out_avail}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("t9_rst_inblk", {63'b0, in_blocked}, 64'd0);
    check("t9_rst_avail", {63'b0, out_avail}, 64'd0);
    check("t9_rst_fd", {63'b0, frame_done}, 64'd0);
    check("t9_rst_data", {63'b0, |out_data}, 64'd0);
    reset    = 1'b0;
    in_avail = 1'b1;
    in_data  = make_cfg(3.0, 0.0, 0.0, 0.0, 8, 1, 50);
    @(negedge clk);
    in_avail = 1'b0;
    exp_q.push_back(64'h0101_0101_0101_0101);
    get_beat("t9", 3, 1'b1, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
